// File: rtl/alu_arbiter_pkg.sv
// alu_arbiter shared types: FSM state, multicycle opcodes, id width.
// No ports; imported by the arbiter, its interface users and sub-modules.
package alu_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] OP_MUL = 4'b1001;
  localparam logic [3:0] OP_REM = 4'b1010;
  localparam int         ID_W   = 1;

  function automatic logic is_mc_op(logic [3:0] op);
    return (op == OP_MUL) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Bundle of requester, shared-ALU and response signals for alu_arbiter.
// slave: arbiter side. master: requesters / ALU / response consumer side.
interface alu_arbiter_if;

  logic        req0_valid;
  logic        req0_ready;
  logic [31:0] req0_a;
  logic [31:0] req0_b;
  logic [3:0]  req0_ctrl;

  logic        req1_valid;
  logic        req1_ready;
  logic [31:0] req1_a;
  logic [31:0] req1_b;
  logic [3:0]  req1_ctrl;

  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_ctrl;
  logic [31:0] alu_result;
  logic        alu_zero;

  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic [31:0] rsp_result;
  logic        rsp_zero;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_ctrl,
    input  req1_valid, req1_a, req1_b, req1_ctrl,
    input  alu_result, alu_zero, rsp_ready,
    output req0_ready, req1_ready,
    output alu_a, alu_b, alu_ctrl,
    output rsp_valid, rsp_id, rsp_result, rsp_zero
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_ctrl,
    output req1_valid, req1_a, req1_b, req1_ctrl,
    output alu_result, alu_zero, rsp_ready,
    input  req0_ready, req1_ready,
    input  alu_a, alu_b, alu_ctrl,
    input  rsp_valid, rsp_id, rsp_result, rsp_zero
  );

endinterface

// File: rtl/alu_arbiter_rr_arb2.sv
// rr_arb2: 2-way round-robin grant. Ports: clk, rst (sync, high),
// valid[1:0], accept pulse in; one-hot grant[1:0] out.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid,
  input  logic       accept,
  output logic [1:0] grant
);

  // ptr=0: req0 has priority on a tie, ptr=1: req1
  logic ptr;

  always_comb begin
    grant = valid;
    if (valid == 2'b11) begin
      grant = ptr ? 2'b10 : 2'b01;
    end
  end

  // after an accept, priority goes to the requester that lost/idled
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= 1'b0;
    end else if (accept) begin
      ptr <= grant[0];
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one external ALU between two requesters.
// Ports: clk, rst (sync, high), bus (alu_arbiter_if.slave). Macro ALU_ARB_MULTICYCLE_EN.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int MC_LAT = 3
) (
  input logic          clk,
  input logic          rst,
  alu_arbiter_if.slave bus
);

  state_t state, state_n;

  logic [1:0]      grant;
  logic            accept;
  logic            last;
  logic [31:0]     sel_a, sel_b;
  logic [3:0]      sel_ctrl;
  logic [31:0]     lat_a, lat_b;
  logic [3:0]      lat_ctrl;
  logic [ID_W-1:0] lat_id;
  logic [31:0]     res_q;
  logic            zero_q;
  logic [ID_W-1:0] id_q;

  rr_arb2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .valid  ({bus.req1_valid, bus.req0_valid}),
    .accept (accept),
    .grant  (grant)
  );

  assign accept = (state == IDLE) && !rst && (|grant);

  assign bus.req0_ready = (state == IDLE) && !rst && grant[0];
  assign bus.req1_ready = (state == IDLE) && !rst && grant[1];

  always_comb begin
    sel_a    = bus.req0_a;
    sel_b    = bus.req0_b;
    sel_ctrl = bus.req0_ctrl;
    unique case (1'b1)
      grant[1]: begin
        sel_a    = bus.req1_a;
        sel_b    = bus.req1_b;
        sel_ctrl = bus.req1_ctrl;
      end
      default: ;
    endcase
  end

`ifdef ALU_ARB_MULTICYCLE_EN
  logic [3:0] cnt;

  // counter holds remaining EXEC cycles after the current one
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= 4'd0;
    end else if (accept) begin
      cnt <= is_mc_op(sel_ctrl) ? 4'(MC_LAT - 1) : 4'd0;
    end else if (state == EXEC && cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
    end
  end

  assign last = (state == EXEC) && (cnt == 4'd0);
`else
  assign last = (state == EXEC);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (accept) state_n = EXEC;
      EXEC: if (last) state_n = RESP;
      RESP: if (bus.rsp_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lat_a    <= '0;
      lat_b    <= '0;
      lat_ctrl <= '0;
      lat_id   <= '0;
      res_q    <= '0;
      zero_q   <= 1'b0;
      id_q     <= '0;
    end else begin
      if (accept) begin
        lat_a    <= sel_a;
        lat_b    <= sel_b;
        lat_ctrl <= sel_ctrl;
        lat_id   <= ID_W'(grant[1]);
      end
      if (last) begin
        res_q  <= bus.alu_result;
        zero_q <= bus.alu_zero;
        id_q   <= lat_id;
      end
    end
  end

  assign bus.alu_a      = lat_a;
  assign bus.alu_b      = lat_b;
  assign bus.alu_ctrl   = lat_ctrl;
  assign bus.rsp_valid  = (state == RESP);
  assign bus.rsp_id     = id_q;
  assign bus.rsp_result = res_q;
  assign bus.rsp_zero   = zero_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: transaction-level model plus
// directed scenarios with hand-computed literal expectations.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  localparam int MC_LAT = 3;
`ifdef ALU_ARB_MULTICYCLE_EN
  localparam bit MC_EN = 1'b1;
`else
  localparam bit MC_EN = 1'b0;
`endif
  localparam logic [3:0] ADD = 4'b0000;
  localparam logic [3:0] SUB = 4'b0001;
  localparam logic [3:0] XOR = 4'b0100;
  localparam logic [3:0] INV = 4'b1111;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  alu_arbiter_if bus();

  alu_arbiter #(.MC_LAT(MC_LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] alu_f(logic [3:0] c, logic [31:0] a,
                                        logic [31:0] b);
    case (c)
      ADD:     return a + b;
      SUB:     return a - b;
      XOR:     return a ^ b;
      OP_MUL:  return a * b;
      OP_REM:  return (b == 0) ? a : a % b;
      default: return ~a;
    endcase
  endfunction

  // external ALU model
  always_comb begin
    logic [31:0] r;
    r = alu_f(bus.alu_ctrl, bus.alu_a, bus.alu_b);
    bus.alu_result = r;
    bus.alu_zero   = (r == 32'd0);
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  // transaction model: busy from accept until response handshake,
  // response visible from a computed cycle number onward
  bit          m_on = 1'b0;
  bit          m_busy = 1'b0;
  int          m_rsp_cyc = 0;
  bit          m_ptr = 1'b0;
  logic [31:0] m_a = '0, m_b = '0, m_res = '0;
  logic [3:0]  m_c = '0;
  bit          m_id = 1'b0, m_zero = 1'b0;

  always @(negedge clk) begin : cmp
    bit g0, g1, rv, mc;
    if (m_on) begin
      g0 = 1'b0;
      g1 = 1'b0;
      if (!m_busy && !rst) begin
        if (bus.req0_valid && bus.req1_valid) begin
          g0 = !m_ptr;
          g1 = m_ptr;
        end else begin
          g0 = bus.req0_valid;
          g1 = bus.req1_valid;
        end
      end
      rv = m_busy && (cyc >= m_rsp_cyc);
      chk("req0_ready", bus.req0_ready, g0);
      chk("req1_ready", bus.req1_ready, g1);
      chk("rsp_valid", bus.rsp_valid, rv);
      chk("alu_a", bus.alu_a, m_a);
      chk("alu_b", bus.alu_b, m_b);
      chk("alu_ctrl", bus.alu_ctrl, m_c);
      if (rv) begin
        chk("rsp_id", bus.rsp_id, m_id);
        chk("rsp_result", bus.rsp_result, m_res);
        chk("rsp_zero", bus.rsp_zero, m_zero);
      end
      if (rst) begin
        m_busy = 1'b0;
        m_ptr  = 1'b0;
        m_a    = '0;
        m_b    = '0;
        m_c    = '0;
      end else if (g0 || g1) begin
        m_id   = g1;
        m_a    = g1 ? bus.req1_a : bus.req0_a;
        m_b    = g1 ? bus.req1_b : bus.req0_b;
        m_c    = g1 ? bus.req1_ctrl : bus.req0_ctrl;
        m_res  = alu_f(m_c, m_a, m_b);
        m_zero = (m_res == 32'd0);
        mc     = MC_EN && (m_c == OP_MUL || m_c == OP_REM);
        m_rsp_cyc = cyc + 1 + (mc ? MC_LAT : 1);
        m_busy = 1'b1;
        m_ptr  = !g1;
      end else if (rv && bus.rsp_ready) begin
        m_busy = 1'b0;
      end
    end
  end

  task automatic wait_acc(input bit id, output int t);
    t = -1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (id ? (bus.req1_valid && bus.req1_ready)
             : (bus.req0_valid && bus.req0_ready)) begin
        t = cyc;
        break;
      end
    end
    if (t < 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL accept_timeout: no accept for req%0d", id);
    end
  endtask

  task automatic wait_rsp(input int t0, input int lat, input bit id,
                          input logic [31:0] res, input bit z,
                          output int th);
    th = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) begin
        th = cyc;
        break;
      end
    end
    if (th < 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL rsp_timeout: no response, expected %0h", res);
    end else begin
      chk("lit_latency", 32'(th - t0), 32'(lat));
      chk("lit_rsp_id", bus.rsp_id, id);
      chk("lit_rsp_result", bus.rsp_result, res);
      chk("lit_rsp_zero", bus.rsp_zero, z);
    end
  endtask

  task automatic drive(input bit id, input bit v, input logic [31:0] a,
                       input logic [31:0] b, input logic [3:0] c);
    if (id) begin
      bus.req1_valid = v;
      bus.req1_a = a;
      bus.req1_b = b;
      bus.req1_ctrl = c;
    end else begin
      bus.req0_valid = v;
      bus.req0_a = a;
      bus.req0_b = b;
      bus.req0_ctrl = c;
    end
  endtask

  initial begin
    int t, th, lat;
    int gids[$], accs[$];
    logic [31:0] rres[$];
    bit rz[$];

    drive(1'b1, 1'b0, 0, 0, 4'd0);
    bus.rsp_ready = 1'b1;
    // req0 ADD 5+7 is already valid during reset: must not be accepted
    drive(1'b0, 1'b1, 32'd5, 32'd7, ADD);
    @(posedge clk); #1;
    m_on = 1'b1;
    @(posedge clk); #1;
    chk("rst_req0_ready", bus.req0_ready, 1'b0);
    chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
    chk("rst_rsp_result", bus.rsp_result, 32'd0);
    chk("rst_rsp_id", bus.rsp_id, 1'b0);
    chk("rst_rsp_zero", bus.rsp_zero, 1'b0);
    chk("rst_alu_a", bus.alu_a, 32'd0);
    chk("rst_alu_ctrl", bus.alu_ctrl, 4'd0);
    rst = 1'b0;

    // ADD 5+7 alone
    wait_acc(1'b0, t);
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    wait_rsp(t, 2, 1'b0, 32'd12, 1'b0, th);

    // both valid every cycle: grants alternate starting at req0
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    drive(1'b0, 1'b1, 32'd9, 32'd9, SUB);
    drive(1'b1, 1'b1, 32'd3, 32'd1, XOR);
    for (int i = 0; i < 60 && rres.size() < 4; i++) begin
      @(negedge clk);
      if (bus.req0_valid && bus.req0_ready) begin
        gids.push_back(0);
        accs.push_back(cyc);
      end
      if (bus.req1_valid && bus.req1_ready) begin
        gids.push_back(1);
        accs.push_back(cyc);
      end
      if (bus.rsp_valid && bus.rsp_ready) begin
        rres.push_back(bus.rsp_result);
        rz.push_back(bus.rsp_zero);
      end
    end
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    if (gids.size() < 4 || rres.size() < 4) begin
      n_cmp++;
      n_bad++;
      $display("FAIL rr_timeout: %0d grants %0d responses",
               gids.size(), rres.size());
    end else begin
      chk("rr_grant0", gids[0], 0);
      chk("rr_grant1", gids[1], 1);
      chk("rr_grant2", gids[2], 0);
      chk("rr_grant3", gids[3], 1);
      chk("rr_res0", rres[0], 32'd0);
      chk("rr_zero0", rz[0], 1'b1);
      chk("rr_res1", rres[1], 32'd2);
      chk("rr_zero1", rz[1], 1'b0);
      chk("rr_gap", 32'(accs[1] - accs[0]), 32'd3);
    end

    // MUL 6*7 from req1, alu_ctrl held through EXEC
    lat = MC_EN ? MC_LAT : 1;
    drive(1'b1, 1'b1, 32'd6, 32'd7, OP_MUL);
    wait_acc(1'b1, t);
    @(posedge clk); #1;
    bus.req1_valid = 1'b0;
    for (int k = 0; k < lat; k++) begin
      @(negedge clk);
      chk("mul_alu_ctrl", bus.alu_ctrl, OP_MUL);
    end
    wait_rsp(t, lat + 1, 1'b1, 32'd42, 1'b0, th);

    // REM 17%5 from req0
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 32'd17, 32'd5, OP_REM);
    wait_acc(1'b0, t);
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    wait_rsp(t, lat + 1, 1'b0, 32'd2, 1'b0, th);

    // unknown opcode passes through to the ALU untouched
    @(posedge clk); #1;
    drive(1'b1, 1'b1, 32'hFFFF_FFFF, 32'd3, INV);
    wait_acc(1'b1, t);
    @(posedge clk); #1;
    bus.req1_valid = 1'b0;
    @(negedge clk);
    chk("inv_alu_ctrl", bus.alu_ctrl, INV);
    wait_rsp(t, 2, 1'b1, 32'd0, 1'b1, th);

    // backpressure: wrap-around add to zero, held 5 cycles
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    drive(1'b1, 1'b1, 32'hFFFF_FFFF, 32'd1, ADD);
    wait_acc(1'b1, t);
    @(posedge clk); #1;
    bus.req1_valid = 1'b0;
    drive(1'b0, 1'b1, 32'd2, 32'd3, ADD);
    wait_rsp(t, 2, 1'b1, 32'd0, 1'b1, th);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("bp_rsp_valid", bus.rsp_valid, 1'b1);
      chk("bp_rsp_result", bus.rsp_result, 32'd0);
      chk("bp_req0_ready", bus.req0_ready, 1'b0);
    end
    @(posedge clk); #1;
    bus.rsp_ready = 1'b1;
    wait_acc(1'b0, t);
    chk("bp_next_accept", 32'(t - th), 32'd6);
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    wait_rsp(t, 2, 1'b0, 32'd5, 1'b0, th);

    // reset during EXEC of a MUL aborts it and restores priority
    @(posedge clk); #1;
    drive(1'b1, 1'b1, 32'd6, 32'd7, OP_MUL);
    wait_acc(1'b1, t);
    @(posedge clk); #1;
    bus.req1_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("abort_no_rsp", bus.rsp_valid, 1'b0);
    end
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 32'd1, 32'd1, ADD);
    drive(1'b1, 1'b1, 32'd2, 32'd2, ADD);
    @(negedge clk);
    t = cyc;
    chk("abort_ptr_r0", bus.req0_ready, 1'b1);
    chk("abort_ptr_r1", bus.req1_ready, 1'b0);
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    wait_rsp(t, 2, 1'b0, 32'd2, 1'b0, th);

    repeat (3) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: MC_LAT, 3, EXEC cycles for MUL (4'b1001) and REMAINDER (4'b1010) when multicycle feature is compiled in; legal range 2..15.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset; synchronous and active-high.
REQ-004 Ports: req0_valid/req1_valid  input  1  requester N has an operation pending.
REQ-005 Ports: req0_ready/req1_ready  output  1  requester N operation accepted this cycle when valid&ready.
REQ-006 Ports: req0_a/req0_b/req1_a/req1_b  input  32  operands; req0_ctrl/req1_ctrl  input  4  ALU opcode.
REQ-007 Ports: alu_a/alu_b  output  32, alu_ctrl  output  4  drive shared ALU; alu_result  input  32, alu_zero  input  1  from shared ALU.
REQ-008 Ports: rsp_valid  output  1; rsp_ready  input  1; rsp_id  output  1 (0=req0, 1=req1); rsp_result  output  32; rsp_zero  output  1.

Function
REQ-009 FSM states IDLE, EXEC, RESP; IDLE->EXEC on accept; EXEC->RESP when cycle counter reaches zero; RESP->IDLE on rsp_valid&rsp_ready.
REQ-010 reqN_ready SHALL be 1 only in IDLE and only for the granted requester; at most one ready high per cycle.
REQ-011 Grant: round-robin; if only one valid, it wins; if both valid, the requester indicated by priority pointer wins; pointer moves to the other requester after every accept.
REQ-012 On accept, operands, opcode and requester id SHALL be latched; alu_a/alu_b/alu_ctrl SHALL come only from latched registers (stable throughout EXEC, independent of request inputs).
REQ-013 EXEC length: 1 cycle for all opcodes, except MUL/REM which take MC_LAT cycles when feature enabled.
REQ-014 On last EXEC cycle, alu_result/alu_zero SHALL be registered into rsp_result/rsp_zero; rsp_valid=1 from next cycle.
REQ-015 Latency: accept in cycle T -> rsp_valid at T+2 (single-cycle op) or T+1+MC_LAT (multicycle op).
REQ-016 In RESP, rsp_valid, rsp_id, rsp_result, rsp_zero SHALL hold stable until rsp_ready=1; backpressure stalls indefinitely.
REQ-017 Earliest next accept: cycle after response handshake; no acceptance in EXEC or RESP.
REQ-018 Invalid opcodes (4'b1111) pass through unchanged; arbiter does not decode opcodes except MUL/REM detection.
REQ-019 Request input changes while not ready SHALL have no effect.

Reset
REQ-020 rst=1 SHALL force: state IDLE, priority pointer to req0, counter 0, rsp_valid 0, rsp_id 0, rsp_result 0, rsp_zero 0, latched operands/opcode 0 (alu_a/alu_b/alu_ctrl=0), both readys 0 during reset cycle.
REQ-021 rst asserted mid-EXEC or in RESP SHALL abort the operation; no response is produced for it.

Configuration
REQ-022 Macro ALU_ARB_MULTICYCLE_EN: defined -> MUL/REM occupy EXEC for MC_LAT cycles (ALU path treated as multicycle); undefined -> all opcodes 1 EXEC cycle, counter logic and MC_LAT unused.

Structure
REQ-023 Shared package SHALL hold: FSM state enum, opcode constants for MUL (4'b1001) and REMAINDER (4'b1010), requester id width constant.
REQ-024 One sub-module: rr_arb2 (2-way round-robin grant with pointer, inputs valid[1:0] and accept pulse, output one-hot grant).
REQ-025 ALU is not instantiated inside; it is connected externally at the parent level.

Verification
REQ-026 Reset then req0 ADD A=5,B=7 alone, rsp_ready=1 -> rsp_valid at T+2, rsp_id=0, rsp_result=12, rsp_zero=0.
REQ-027 Both valid every cycle, req0 SUB 9-9, req1 XOR 3^1, rsp_ready=1 -> grants alternate 0,1,0,...; first rsp result 0 zero=1, second result 2.
REQ-028 With ALU_ARB_MULTICYCLE_EN, MC_LAT=3, req1 MUL 6*7 -> rsp_valid at T+4, rsp_result=42; alu_ctrl=4'b1001 stable for 3 cycles.
REQ-029 rsp_ready held 0 for 5 cycles after rsp_valid -> outputs stable, both readys 0; rsp_ready=1 -> IDLE next cycle, new accept possible.
REQ-030 rst asserted in EXEC of a MUL -> next cycle IDLE, rsp_valid=0, pointer=req0; no stale response appears afterwards.
